// File: rtl/mux_32.sv
// 2:1 word selector for the datapath: combinational output C plus a registered copy C_reg
// for pipeline-stage use. Only C_reg is affected by clk and rst.
module mux_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             select,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] C_reg
);

    logic [WIDTH-1:0] c_reg_d;
    logic [WIDTH-1:0] c_reg_q;

    // ?: keeps bits where A == B resolved when select is X/Z.
    always_comb begin
        C = select ? B : A;
    end

    always_comb begin
        c_reg_d = C;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_reg_q <= '0;
        end else begin
            c_reg_q <= c_reg_d;
        end
    end

    assign C_reg = c_reg_q;

endmodule

// File: tb/tb_mux_32.sv
// Self-checking bench for mux_32: vector table, hand-written reset/latency sequences and
// randomized traffic checked against a behavioural model.
module tb_mux_32;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic        select;
    logic [31:0] C;
    logic [31:0] C_reg;

    int unsigned n_tests;
    int unsigned n_fail;
    logic [31:0] exp_reg;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sel;
        logic [31:0] exp_c;
    } vec_t;

    vec_t vecs[8];

    mux_32 #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .select (select),
        .C      (C),
        .C_reg  (C_reg)
    );

    // Behavioural reference: select 0 chooses A, select 1 chooses B.
    function automatic logic [31:0] model_sel(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        logic [31:0] r;
        if (s == 1'b1) r = b;
        else r = a;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, want);
        end
    endtask

    // One full clock period; the model register follows the pre-edge selected word.
    task automatic tick();
        #5;
        if (!rst) exp_reg = model_sel(A, B, select);
        clk = 1'b1;
        #5;
        clk = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_reg = '0;
        clk     = 1'b0;
        rst     = 1'b1;
        A       = 32'h1234_5678;
        B       = 32'h9ABC_DEF0;
        select  = 1'b0;

        vecs[0] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
        vecs[1] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
        vecs[2] = '{32'h8000_0001, 32'h7FFF_FFFE, 1'b0, 32'h8000_0001};
        vecs[3] = '{32'h8000_0001, 32'h7FFF_FFFE, 1'b1, 32'h7FFF_FFFE};
        vecs[4] = '{32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D};
        vecs[5] = '{32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 32'hDEAD_BEEF};
        vecs[6] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5};
        vecs[7] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5};

        // Reset phase with clock idle
        #10;
        check("rst_sel0_C", C, 32'h1234_5678);
        check("rst_sel0_Creg", C_reg, 32'h0000_0000);
        select = 1'b1;
        #10;
        check("rst_sel1_C", C, 32'h9ABC_DEF0);
        check("rst_sel1_Creg", C_reg, 32'h0000_0000);
        tick();
        check("rst_hold_across_edge", C_reg, 32'h0000_0000);

        // Release reset, one-cycle latency
        rst    = 1'b0;
        select = 1'b0;
        tick();
        check("first_capture_A", C_reg, 32'h1234_5678);
        select = 1'b1;
        #1;
        check("latency_before_edge", C_reg, 32'h1234_5678);
        tick();
        check("second_capture_B", C_reg, 32'h9ABC_DEF0);

        // Table-driven combinational vectors
        for (int i = 0; i < 8; i++) begin
            A      = vecs[i].a;
            B      = vecs[i].b;
            select = vecs[i].sel;
            #2;
            check($sformatf("vec%0d_C", i), C, vecs[i].exp_c);
            tick();
            check($sformatf("vec%0d_Creg", i), C_reg, vecs[i].exp_c);
        end

        // Randomized traffic, select toggles each iteration
        for (int i = 0; i < 100; i++) begin
            logic [31:0] prev_c;
            A      = $urandom;
            B      = $urandom;
            select = i[0];
            #2;
            prev_c = model_sel(A, B, select);
            check($sformatf("rand%0d_C", i), C, prev_c);
            tick();
            check($sformatf("rand%0d_Creg", i), C_reg, exp_reg);
            check($sformatf("rand%0d_Creg_prevC", i), C_reg, prev_c);
        end

        // Asynchronous reset mid-cycle
        A      = 32'hFFFF_FFFF;
        B      = 32'h0000_0000;
        select = 1'b0;
        tick();
        check("pre_async_Creg", C_reg, 32'hFFFF_FFFF);
        #2;
        rst = 1'b1;
        exp_reg = '0;
        #1;
        check("async_rst_Creg", C_reg, 32'h0000_0000);
        check("async_rst_C", C, 32'hFFFF_FFFF);
        tick();
        check("async_rst_hold", C_reg, 32'h0000_0000);
        #2;
        rst = 1'b0;
        #1;
        check("rst_release_no_edge", C_reg, 32'h0000_0000);
        tick();
        check("rst_release_capture", C_reg, 32'hFFFF_FFFF);

        // A == B: output constant regardless of select
        A = 32'hA5A5_A5A5;
        B = 32'hA5A5_A5A5;
        for (int i = 0; i < 4; i++) begin
            select = ~select;
            #1;
            check($sformatf("equal_ab%0d", i), C, 32'hA5A5_A5A5);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_32.md
Name: mux_32

Overview:
- 32-bit 2:1 data selector used throughout the RISC-V datapath, e.g. for ALU operand select, PC source and write-back source.
- Primary output C is purely combinational, with zero latency from A, B and select.
- A registered copy of the selected word (C_reg) is also provided for pipeline-stage use; it is clocked by the core clock and cleared by the core reset.

Parameters:
- WIDTH, 32, data width of A, B, C and C_reg in bits.

Ports:
- clk  input  1  core clock; rising-edge active; drives C_reg only.
- rst  input  1  asynchronous, active-high reset; clears C_reg.
- A  input  WIDTH  data input, selected when select = 0.
- B  input  WIDTH  data input, selected when select = 1.
- select  input  1  selection control.
- C  output  WIDTH  combinational selected word.
- C_reg  output  WIDTH  registered selected word.

Interface decision: one clock (clk); reset rst is asynchronous and active-high.

Behaviour:
Combinational output C:
- select = 0: C = A.
- select = 1: C = B.
- All bits are passed unmodified; no sign or zero extension; no gating.
- Combinational function of A, B and select only; independent of clk and rst.
- Valid within propagation delay of any input change; must be settled well under 10 ns in simulation (zero-delay RTL).
- C is never affected by rst, including while rst is asserted.

X/Z handling on select:
- If select is X or Z, C is X in simulation; no priority to either input.
- Exception: bits where A and B are equal may resolve to that value, as standard ?: semantics allow.

Registered output C_reg:
- On every rising edge of clk with rst low, C_reg takes the value C had just before the edge, so C_reg = select ? B : A sampled at the edge.
- Latency from input to C_reg: 1 clock cycle.
- No enable; updates every cycle.

Reset:
- rst high clears C_reg to all zeros immediately, without waiting for a clock edge.
- C_reg holds zero while rst is high, even across clock edges.
- On the first rising edge after rst deasserts, C_reg loads the selected word.
- rst asserted in the middle of a cycle clears C_reg at once; the next capture happens at the first edge with rst low.

Simultaneous and boundary events:
- select toggling at the same time as a clock edge: C_reg captures the pre-edge value (standard nonblocking register semantics).
- A = B: C = A regardless of select.
- No internal state other than C_reg; no handshake; no wrap-around conditions.

Test Plan:
- rst = 1, A = 0x12345678, B = 0x9ABCDEF0, select = 0, wait 10 ns -> C = 0x12345678; C_reg = 0x00000000.
- Same A/B, select = 1, wait 10 ns with clk idle -> C = 0x9ABCDEF0; C_reg still 0.
- Deassert rst; select = 0, then one rising clk edge -> C_reg = 0x12345678. Set select = 1, next edge -> C_reg = 0x9ABCDEF0 (one-cycle latency).
- Random A/B, 100 iterations toggling select each iteration, check after 10 ns -> C = A when select = 0, C = B when select = 1; C_reg equals the value of C from the previous cycle.
- Assert rst between clock edges while C_reg = 0xFFFFFFFF (A = 0xFFFFFFFF, select = 0) -> C_reg = 0 immediately; C still 0xFFFFFFFF.
- A = B = 0xA5A5A5A5, toggle select -> C stays 0xA5A5A5A5 with no glitch reported.
